// File: rtl/xtrap_dump_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xtrap_dump_pkg : shared FSM states and dump-header field layout  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package xtrap_dump_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_HDR  = 3'd1,
    ST_PREF = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Header is three words; index of the final one.
  localparam logic [1:0] HDR_LAST = 2'd2;

  // word2 layout: {cause, data_we, data_addr}, data_addr in the low bits.
  function automatic int word2_we_bit(input int addr_w);
    return addr_w;
  endfunction

  function automatic int word2_cause_bit(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xtrap_dump_skid.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xtrap_dump_skid : one-entry holding register with valid flag     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module xtrap_dump_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  // A push in the same cycle as a pop refills the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xtrap_dump.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xtrap_dump : on trap/request, freeze and stream a state dump      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module xtrap_dump
  import xtrap_dump_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REGF_ADDR_W = 4,
  parameter int ADDR_W      = 13,
  parameter int PC_W        = 10,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trap,
  input  logic                   dump_req,
  input  logic                   data_we,
  input  logic [ADDR_W-1:0]      data_addr,
  input  logic [PC_W-1:0]        pc,
  output logic [REGF_ADDR_W-1:0] regf_addr,
  input  logic [DATA_W-1:0]      regf_data,
  output logic [DATA_W-1:0]      dump_data,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic                   dump_last,
  output logic                   halted,
  output logic [CNT_W-1:0]       cycles
);

  localparam int               N         = 2 ** REGF_ADDR_W;
  localparam int               IDX_W     = REGF_ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_N     = IDX_W'(N);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam int               WE_BIT    = word2_we_bit(ADDR_W);
  localparam int               CAUSE_BIT = word2_cause_bit(ADDR_W);
  localparam int               CYC_BITS  = min_int(CNT_W, DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state;
  state_t             state_nxt;

  logic [PC_W-1:0]    cap_pc;
  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_we;
  logic               cap_cause;
  logic [1:0]         hdr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               pend;
  logic               pend_last;

  logic               trigger;
  logic               xfer;
  logic               out_free;
  logic               issue;
  logic               room;
  logic [1:0]         occ;
  logic               skid_push;
  logic               skid_pop;
  logic               skid_valid;
  logic [DATA_W:0]    skid_dout;
  logic [DATA_W-1:0]  word0;
  logic [DATA_W-1:0]  word1;
  logic [DATA_W-1:0]  word2;

  assign regf_addr = rd_idx[REGF_ADDR_W-1:0];

  always_comb begin
    word0 = '0;
    word0[CYC_BITS-1:0] = cycles[CYC_BITS-1:0];
    word1 = '0;
    word1[PC_W-1:0] = cap_pc;
    word2 = '0;
    word2[ADDR_W-1:0] = cap_addr;
    word2[WE_BIT]     = cap_we;
    word2[CAUSE_BIT]  = cap_cause;
  end

  // Occupancy = output word + held word + read in flight; a new read may be
  // issued only if its data is guaranteed a slot when it returns.
  always_comb begin
    trigger   = 1'b0;
    xfer      = dump_valid & dump_ready;
    out_free  = ~dump_valid | dump_ready;
    occ       = {1'b0, dump_valid} + {1'b0, skid_valid} + {1'b0, pend};
    room      = (occ - {1'b0, xfer}) < 2'd2;
    issue     = 1'b0;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    halted    = (state != ST_RUN);
    case (state)
      ST_RUN:  trigger = trap | dump_req;
      ST_PREF: issue   = 1'b1;
      ST_SEND: begin
        issue     = (rd_idx < IDX_N) & room;
        skid_pop  = out_free & skid_valid;
        skid_push = pend & ~(out_free & ~skid_valid);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (trigger) state_nxt = ST_HDR;
      ST_HDR:  if (xfer && hdr_idx == HDR_LAST) state_nxt = ST_PREF;
      ST_PREF: state_nxt = ST_SEND;
      ST_SEND: if (xfer && dump_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles     <= '0;
      cap_pc     <= '0;
      cap_addr   <= '0;
      cap_we     <= 1'b0;
      cap_cause  <= 1'b0;
      hdr_idx    <= '0;
      rd_idx     <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue & (rd_idx == IDX_LAST);
      if (issue) rd_idx <= rd_idx + IDX_W'(1);
      case (state)
        ST_RUN: begin
          if (trigger) begin
            // cycles stops here, so it doubles as the latched count.
            cap_pc     <= pc;
            cap_addr   <= data_addr;
            cap_we     <= data_we;
            cap_cause  <= trap;
            hdr_idx    <= '0;
            rd_idx     <= '0;
            dump_data  <= word0;
            dump_valid <= 1'b1;
            dump_last  <= 1'b0;
          end else if (cycles != CNT_MAX) begin
            cycles <= cycles + CNT_W'(1);
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (hdr_idx == HDR_LAST) begin
              dump_valid <= 1'b0;
            end else begin
              hdr_idx   <= hdr_idx + 2'd1;
              dump_data <= (hdr_idx == 2'd0) ? word1 : word2;
            end
          end
        end
        ST_SEND: begin
          if (out_free) begin
            if (skid_valid) begin
              {dump_last, dump_data} <= skid_dout;
              dump_valid             <= 1'b1;
            end else if (pend) begin
              dump_data  <= regf_data;
              dump_last  <= pend_last;
              dump_valid <= 1'b1;
            end else begin
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
            end
          end
        end
        default: begin
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
        end
      endcase
    end
  end

  xtrap_dump_skid #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   ({pend_last, regf_data}),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_xtrap_dump.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_xtrap_dump : directed self-checking bench for xtrap_dump       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_xtrap_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap = 1'b0;
  logic        dump_req = 1'b0;
  logic        data_we = 1'b0;
  logic [12:0] data_addr = '0;
  logic [9:0]  pc = '0;
  logic [3:0]  regf_addr;
  logic [31:0] regf_data = '0;
  logic [31:0] dump_data;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic        dump_last;
  logic        halted;
  logic [31:0] cycles;

  logic        rst4 = 1'b1;
  logic        trap4 = 1'b0;
  logic        dump_req4 = 1'b0;
  logic [3:0]  regf_addr4;
  logic [31:0] regf_data4 = '0;
  logic [31:0] dump_data4;
  logic        dump_valid4;
  logic        dump_ready4 = 1'b0;
  logic        dump_last4;
  logic        halted4;
  logic [3:0]  cycles4;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] got_data [0:31];
  logic        got_last [0:31];
  int          got_cyc  [0:31];
  int          n_got;
  int          stall_bad;
  bit          timed_out;

  always #5 clk = ~clk;

  // Register file model: one-cycle read latency, reg[k] = k + 0x10.
  always @(posedge clk) regf_data <= 32'h10 + {28'd0, regf_addr};

  xtrap_dump dut (
    .clk(clk), .rst(rst), .trap(trap), .dump_req(dump_req), .data_we(data_we),
    .data_addr(data_addr), .pc(pc), .regf_addr(regf_addr), .regf_data(regf_data),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_last(dump_last), .halted(halted), .cycles(cycles)
  );

  xtrap_dump #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .trap(trap4), .dump_req(dump_req4), .data_we(data_we),
    .data_addr(data_addr), .pc(pc), .regf_addr(regf_addr4), .regf_data(regf_data4),
    .dump_data(dump_data4), .dump_valid(dump_valid4), .dump_ready(dump_ready4),
    .dump_last(dump_last4), .halted(halted4), .cycles(cycles4)
  );

  task automatic do_reset();
    rst = 1'b1; trap = 1'b0; dump_req = 1'b0; dump_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Records transfers; mode 0 = ready always high, mode 1 = ready 1,0,0,1 repeating.
  task automatic capture(input int mode, input int trap_at);
    logic [31:0] hold_data;
    logic        hold_last;
    bit          have_hold;
    bit          done;
    n_got = 0; stall_bad = 0; timed_out = 0; have_hold = 0; done = 0;
    hold_data = '0; hold_last = 1'b0;
    for (int i = 0; i < 32; i++) begin
      got_data[i] = '0; got_last[i] = 1'b0; got_cyc[i] = -1;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      dump_ready = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
      trap = (c == trap_at);
      if (have_hold && (dump_valid !== 1'b1 || dump_data !== hold_data || dump_last !== hold_last))
        stall_bad++;
      have_hold = 0;
      if (dump_valid === 1'b1) begin
        if (dump_ready) begin
          if (n_got < 32) begin
            got_data[n_got] = dump_data; got_last[n_got] = dump_last; got_cyc[n_got] = c;
          end
          n_got++;
          if (dump_last === 1'b1 || n_got >= 32) done = 1;
        end else begin
          have_hold = 1; hold_data = dump_data; hold_last = dump_last;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    trap = 1'b0; dump_ready = 1'b1;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", dump_valid); end
    checks++; if (dump_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", dump_last); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
    checks++; if (regf_addr !== 4'd0) begin errors++; $display("FAIL reset_regf_addr: got %0d expected 0", regf_addr); end
    checks++; if (dump_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", dump_data); end
  endtask

  task automatic test_main_dump();
    int lasts;
    do_reset();
    pc = 10'h2A5; data_addr = 13'h0123; data_we = 1'b0;
    advance(100);
    checks++; if (cycles !== 32'd100) begin errors++; $display("FAIL cycles_count: got %0d expected 100", cycles); end
    trap = 1'b1;
    @(posedge clk); @(negedge clk);
    trap = 1'b0; pc = 10'h000; data_addr = 13'h0000; data_we = 1'b1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL main_halted: got %0b expected 1", halted); end
    capture(0, -1);
    checks++; if (timed_out || n_got != 19) begin errors++; $display("FAIL main_count: got %0d words (timeout %0b) expected 19", n_got, timed_out); end
    checks++; if (got_cyc[0] != 0) begin errors++; $display("FAIL main_first_valid: got cycle %0d expected 0", got_cyc[0]); end
    checks++; if (got_data[0] !== 32'd100) begin errors++; $display("FAIL main_word0: got %0d expected 100", got_data[0]); end
    checks++; if (got_data[1] !== 32'h2A5) begin errors++; $display("FAIL main_word1: got %0h expected 2a5", got_data[1]); end
    checks++; if (got_data[2] !== 32'h4123) begin errors++; $display("FAIL main_word2: got %0h expected 4123", got_data[2]); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_data[3+k] !== 32'h10 + k) begin
        errors++; $display("FAIL main_reg%0d: got %0h expected %0h", k, got_data[3+k], 32'h10 + k);
      end
    end
    for (int k = 3; k < 18; k++) begin
      checks++;
      if (got_cyc[k+1] - got_cyc[k] != 1) begin
        errors++; $display("FAIL main_rate_word%0d: got gap %0d expected 1", k, got_cyc[k+1] - got_cyc[k]);
      end
    end
    lasts = 0;
    for (int k = 0; k < 18; k++) if (got_last[k] === 1'b1) lasts++;
    checks++; if (lasts != 0 || got_last[18] !== 1'b1) begin errors++; $display("FAIL main_last: got early=%0d final=%0b expected early=0 final=1", lasts, got_last[18]); end
    trap = 1'b1;
    @(posedge clk); @(negedge clk);
    trap = 1'b0;
    advance(2);
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL done_valid: got %0b expected 0", dump_valid); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL done_halted: got %0b expected 1", halted); end
    checks++; if (cycles !== 32'd100) begin errors++; $display("FAIL done_cycles_frozen: got %0d expected 100", cycles); end
  endtask

  task automatic test_backpressure();
    int lasts;
    do_reset();
    advance(7);
    pc = 10'h3FF; data_addr = 13'h1FFF; data_we = 1'b1;
    trap = 1'b1; dump_req = 1'b1;
    @(posedge clk); @(negedge clk);
    trap = 1'b0; dump_req = 1'b0;
    capture(1, 8);
    checks++; if (timed_out || n_got != 19) begin errors++; $display("FAIL bp_count: got %0d words (timeout %0b) expected 19", n_got, timed_out); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_bad); end
    checks++; if (got_data[0] !== 32'd7) begin errors++; $display("FAIL bp_word0: got %0d expected 7", got_data[0]); end
    checks++; if (got_data[1] !== 32'h3FF) begin errors++; $display("FAIL bp_word1: got %0h expected 3ff", got_data[1]); end
    checks++; if (got_data[2] !== 32'h7FFF) begin errors++; $display("FAIL bp_word2: got %0h expected 7fff", got_data[2]); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_data[3+k] !== 32'h10 + k) begin
        errors++; $display("FAIL bp_reg%0d: got %0h expected %0h", k, got_data[3+k], 32'h10 + k);
      end
    end
    lasts = 0;
    for (int k = 0; k < 18; k++) if (got_last[k] === 1'b1) lasts++;
    checks++; if (lasts != 0 || got_last[18] !== 1'b1) begin errors++; $display("FAIL bp_last: got early=%0d final=%0b expected early=0 final=1", lasts, got_last[18]); end
  endtask

  task automatic test_dump_req();
    do_reset();
    advance(3);
    pc = 10'h001; data_addr = 13'h1ABC; data_we = 1'b1;
    dump_req = 1'b1;
    @(posedge clk); @(negedge clk);
    dump_req = 1'b0;
    capture(0, -1);
    checks++; if (timed_out || n_got != 19) begin errors++; $display("FAIL req_count: got %0d words (timeout %0b) expected 19", n_got, timed_out); end
    checks++; if (got_data[0] !== 32'd3) begin errors++; $display("FAIL req_word0: got %0d expected 3", got_data[0]); end
    checks++; if (got_data[1] !== 32'h1) begin errors++; $display("FAIL req_word1: got %0h expected 1", got_data[1]); end
    checks++; if (got_data[2] !== 32'h3ABC) begin errors++; $display("FAIL req_word2: got %0h expected 3abc", got_data[2]); end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    advance(5);
    trap = 1'b1;
    @(posedge clk); @(negedge clk);
    trap = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dump_valid === 1'b1 && dump_data === 32'h15) found = 1;
      else begin @(posedge clk); @(negedge clk); end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach_reg5: got none expected word 15 within 40 cycles"); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", dump_valid); end
    checks++; if (dump_last !== 1'b0) begin errors++; $display("FAIL mid_last: got %0b expected 0", dump_last); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted: got %0b expected 0", halted); end
    checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL mid_cycles: got %0d expected 0", cycles); end
    rst = 1'b0;
    advance(4);
    checks++; if (cycles !== 32'd4) begin errors++; $display("FAIL mid_restart: got %0d expected 4", cycles); end
  endtask

  task automatic test_saturate();
    rst4 = 1'b0;
    advance(20);
    checks++; if (cycles4 !== 4'hF) begin errors++; $display("FAIL sat_cycles: got %0d expected 15", cycles4); end
    trap4 = 1'b1;
    @(posedge clk); @(negedge clk);
    trap4 = 1'b0;
    checks++; if (dump_valid4 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b expected 1", dump_valid4); end
    checks++; if (dump_data4 !== 32'd15) begin errors++; $display("FAIL sat_word0: got %0d expected 15", dump_data4); end
    checks++; if (halted4 !== 1'b1) begin errors++; $display("FAIL sat_halted: got %0b expected 1", halted4); end
  endtask

  initial begin
    test_reset();
    test_main_dump();
    test_backpressure();
    test_dump_req();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/xtrap_dump.md
XTRAP_DUMP -- requirements
Module: xtrap_dump

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  32  register file word and stream width
  REGF_ADDR_W  4  register file address width; N = 2**REGF_ADDR_W registers dumped
  ADDR_W  13  data bus address width
  PC_W  10  program counter width
  CNT_W  32  cycle counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  trap  in  1  core trap indication
  dump_req  in  1  external dump request pulse
  data_we  in  1  core data write enable
  data_addr  in  ADDR_W  core data address
  pc  in  PC_W  core program counter
  regf_addr  out  REGF_ADDR_W  register file read address
  regf_data  in  DATA_W  register file read data, one-cycle latency
  dump_data  out  DATA_W  stream word
  dump_valid  out  1  stream word valid
  dump_ready  in  1  sink ready
  dump_last  out  1  final stream word marker
  halted  out  1  capture taken, core should stall
  cycles  out  CNT_W  running cycle count

Function
REQ-003 States SHALL be RUN, HDR, PREF, SEND, DONE.
REQ-004 In RUN, cycles SHALL increment by 1 each clock starting from 0 after reset, saturating at all-ones.
REQ-005 In RUN, trap or dump_req sampled high SHALL latch cycles, pc, data_addr, data_we and cause (1 = trap, 0 = dump_req), then enter HDR next cycle; cycles freezes.
REQ-006 Trap and dump_req high together SHALL record cause = 1.
REQ-007 trap and dump_req outside RUN SHALL be ignored.
REQ-008 The stream SHALL be 3+N words in order: word0 = latched cycles (truncated or zero-extended to DATA_W); word1 = latched pc zero-extended; word2 = {cause, data_we, data_addr} zero-extended; then registers 0..N-1.
REQ-009 A word SHALL transfer on a cycle where dump_valid and dump_ready are both high; while dump_valid is high and dump_ready is low, dump_data and dump_last SHALL hold stable.
REQ-010 dump_valid SHALL assert the cycle HDR is entered, with word0.
REQ-011 After word2 transfers, the block SHALL drive regf_addr = 0 in PREF, capture regf_data the next cycle, and present it in SEND.
REQ-012 While a register word is waiting in SEND, the next address SHALL be prefetched into a one-entry holding register, so that with dump_ready held high the stream sustains one word per cycle after the first register word.
REQ-013 dump_last SHALL be high only with register N-1; its transfer SHALL enter DONE.
REQ-014 halted SHALL be high in every state except RUN.
REQ-015 In DONE, dump_valid SHALL be low; the block stays in DONE until rst.
REQ-016 Register index counting SHALL use REGF_ADDR_W+1 bits so that N is reachable without wrap-around.

Reset
REQ-017 On rst, outputs SHALL be: dump_valid 0, dump_last 0, halted 0, cycles 0, regf_addr 0, dump_data 0; state RUN.
REQ-018 rst asserted mid-stream SHALL abort the dump, with dump_valid low the following cycle.
REQ-019 Cycle counting SHALL restart from 0 on the first cycle after rst deasserts.

Structure
REQ-020 The state encoding and word2 field offsets SHALL live in a shared header next to xdefs.vh.
REQ-021 The holding register with valid flag SHALL be one sub-module, xtrap_dump_skid.

Verification
REQ-022 trap at cycle 100, dump_ready always 1, regf[k]=k+0x10 -> 19 words: 100, pc, word2 with bit (ADDR_W+1)=1, then 0x10..0x1F; dump_last on word 19; one word per cycle after the first register word.
REQ-023 dump_ready toggling 1,0,0,1 -> no word lost or duplicated; dump_data stable during stalls.
REQ-024 trap and dump_req asserted in the same cycle -> cause bit 1; second trap during SEND -> ignored, stream unchanged.
REQ-025 dump_req only, data_we=1, data_addr=0x1ABC -> word2 = {0,1,0x1ABC}.
REQ-026 rst during register word 5 -> dump_valid 0 next cycle, halted 0, cycles restart from 0.
REQ-027 CNT_W=4, trap after 20 cycles -> word0 = 15, showing saturation.
